// File: rtl/tf_pkg.sv
// Shared types for the matrix-adder operand sequencer: float word, FSM states,
// and the element count derived from the matrix dimension.
package tf_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FILL_A = 3'd1,
      FILL_B = 3'd2,
      LOAD   = 3'd3,
      WAIT   = 3'd4,
      DRAIN  = 3'd5
   } state_t;

   function automatic int elem_count(input int width);
      return width * width;
   endfunction

endpackage

// File: rtl/tf_operand_sequencer_if.sv
// Serial operand input and serial result output handshakes of the sequencer.
interface tf_operand_sequencer_if;
   import tf_pkg::*;

   logic  in_valid;
   logic  in_ready;
   word_t in_data;
   logic  out_valid;
   logic  out_ready;
   word_t out_data;
   logic  out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );

endinterface

// File: rtl/tf_result_drain.sv
// Result bank capture and serial valid/ready/last streaming of the captured words.
module tf_result_drain
   import tf_pkg::*;
#(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  capture,
   input  word_t result [N-1:0],
   input  logic  out_ready,
   output logic  out_valid,
   output word_t out_data,
   output logic  out_last,
   output logic  done
);

   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   word_t          bank_r [N-1:0];
   logic [IW-1:0]  cnt_r;
   logic [IW-1:0]  nxt_s;
   logic           valid_r;
   logic           last_r;
   word_t          data_r;

   assign nxt_s     = cnt_r + IW'(1);
   assign done      = valid_r && out_ready && last_r;
   assign out_valid = valid_r;
   assign out_data  = data_r;
   assign out_last  = last_r;

   // Capture the adder results, then present one word per accepted handshake.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N; i++) begin
            bank_r[i] <= 32'h0;
         end
         cnt_r   <= {IW{1'b0}};
         valid_r <= 1'b0;
         last_r  <= 1'b0;
         data_r  <= 32'h0;
      end else if (capture) begin
         bank_r  <= result;
         cnt_r   <= {IW{1'b0}};
         valid_r <= 1'b1;
         data_r  <= result[0];
         last_r  <= (LAST_IDX == {IW{1'b0}});
      end else if (valid_r && out_ready) begin
         if (last_r) begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            cnt_r   <= {IW{1'b0}};
         end else begin
            cnt_r  <= nxt_s;
            data_r <= bank_r[nxt_s];
            last_r <= (nxt_s == LAST_IDX);
         end
      end
   end

endmodule

// File: rtl/tf_operand_sequencer.sv
// Operand fill / load / wait controller for the element-wise adder bank.
// Optional WAIT timeout with sticky err output: define TF_SEQ_TIMEOUT_EN.
module tf_operand_sequencer
   import tf_pkg::*;
#(
   parameter  int WIDTH   = 2,
   parameter  int SETTLE  = 2,
   parameter  int TIMEOUT = 1024,
   localparam int N       = elem_count(WIDTH)
) (
   input  logic  clk,
   input  logic  reset,
   tf_operand_sequencer_if.slave bus,
   output logic  add_load,
   input  logic  add_ready,
   output word_t add_a      [N-1:0],
   output word_t add_b      [N-1:0],
   input  word_t add_result [N-1:0],
   output logic  busy
`ifdef TF_SEQ_TIMEOUT_EN
   ,
   output logic  err
`endif
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int SW = $clog2(SETTLE + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   if (SETTLE < 1 || TIMEOUT < 1) begin : g_bad_param
      $error("tf_operand_sequencer: SETTLE and TIMEOUT must be >= 1");
   end

   state_t         state_r;
   logic [IW-1:0]  cnt_r;
   logic [SW-1:0]  settle_r;
   logic           add_load_r;
   logic           busy_r;
   word_t          add_a_r [N-1:0];
   word_t          add_b_r [N-1:0];
   logic           in_ready_s;
   logic           in_fire_s;
   logic           capture_s;
   logic           drain_done_s;

`ifdef TF_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0]  wait_cnt_r;
   logic           err_r;
   assign err = err_r;
`endif

   assign in_ready_s   = (state_r == IDLE) || (state_r == FILL_A) || (state_r == FILL_B);
   assign in_fire_s    = bus.in_valid && in_ready_s;
   // Ready is only trusted once the settle window after the load has elapsed.
   assign capture_s    = (state_r == WAIT) && (settle_r == {SW{1'b0}}) && add_ready;
   assign bus.in_ready = in_ready_s;
   assign add_load     = add_load_r;
   assign busy         = busy_r;
   assign add_a        = add_a_r;
   assign add_b        = add_b_r;

   // Operand fill, load strobe and completion wait.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= IDLE;
         cnt_r      <= {IW{1'b0}};
         settle_r   <= {SW{1'b0}};
         add_load_r <= 1'b0;
         busy_r     <= 1'b0;
         for (int i = 0; i < N; i++) begin
            add_a_r[i] <= 32'h0;
            add_b_r[i] <= 32'h0;
         end
`ifdef TF_SEQ_TIMEOUT_EN
         wait_cnt_r <= {TW{1'b0}};
         err_r      <= 1'b0;
`endif
      end else begin
         add_load_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (in_fire_s) begin
                  add_a_r[0] <= bus.in_data;
                  busy_r     <= 1'b1;
                  cnt_r      <= (N == 1) ? {IW{1'b0}} : IW'(1);
                  state_r    <= (N == 1) ? FILL_B : FILL_A;
`ifdef TF_SEQ_TIMEOUT_EN
                  err_r      <= 1'b0;
`endif
               end
            end
            FILL_A: begin
               if (in_fire_s) begin
                  add_a_r[cnt_r] <= bus.in_data;
                  if (cnt_r == LAST_IDX) begin
                     cnt_r   <= {IW{1'b0}};
                     state_r <= FILL_B;
                  end else begin
                     cnt_r <= cnt_r + IW'(1);
                  end
               end
            end
            FILL_B: begin
               if (in_fire_s) begin
                  add_b_r[cnt_r] <= bus.in_data;
                  if (cnt_r == LAST_IDX) begin
                     cnt_r      <= {IW{1'b0}};
                     state_r    <= LOAD;
                     add_load_r <= 1'b1;
                  end else begin
                     cnt_r <= cnt_r + IW'(1);
                  end
               end
            end
            LOAD: begin
               state_r  <= WAIT;
               settle_r <= SW'(SETTLE);
`ifdef TF_SEQ_TIMEOUT_EN
               wait_cnt_r <= {TW{1'b0}};
`endif
            end
            WAIT: begin
               if (capture_s) begin
                  state_r <= DRAIN;
               end else begin
                  if (settle_r != {SW{1'b0}}) begin
                     settle_r <= settle_r - SW'(1);
                  end
`ifdef TF_SEQ_TIMEOUT_EN
                  if (wait_cnt_r == TW'(TIMEOUT - 1)) begin
                     err_r   <= 1'b1;
                     busy_r  <= 1'b0;
                     state_r <= IDLE;
                  end else begin
                     wait_cnt_r <= wait_cnt_r + TW'(1);
                  end
`endif
               end
            end
            DRAIN: begin
               if (drain_done_s) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   tf_result_drain #(.N(N)) u_drain (
      .clk       (clk),
      .reset     (reset),
      .capture   (capture_s),
      .result    (add_result),
      .out_ready (bus.out_ready),
      .out_valid (bus.out_valid),
      .out_data  (bus.out_data),
      .out_last  (bus.out_last),
      .done      (drain_done_s)
   );

endmodule

// File: tb/tb_tf_operand_sequencer.sv
// Directed bench for tf_operand_sequencer: table of operand/result vectors plus
// hand sequences for backpressure, gaps, stale ready, resets and overlap.
module tb_tf_operand_sequencer;
   import tf_pkg::*;

   localparam int N = 4;

   logic  clk = 1'b0;
   logic  reset = 1'b0;
   logic  add_load;
   logic  add_ready;
   logic  busy;
   word_t add_a [N-1:0];
   word_t add_b [N-1:0];
   word_t add_result [N-1:0];
`ifdef TF_SEQ_TIMEOUT_EN
   logic  err;
`endif

   tf_operand_sequencer_if bus ();

   tf_operand_sequencer #(.WIDTH(2), .SETTLE(2), .TIMEOUT(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus.slave),
      .add_load   (add_load),
      .add_ready  (add_ready),
      .add_a      (add_a),
      .add_b      (add_b),
      .add_result (add_result),
      .busy       (busy)
`ifdef TF_SEQ_TIMEOUT_EN
      ,
      .err        (err)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      word_t a   [4];
      word_t b   [4];
      word_t sum [4];
   } vec_t;

   vec_t vecs [3];
   int   passed = 0;
   int   total = 0;
   int   cyc = 0;
   int   load_cnt = 0;
   int   lc_start = 0;
   int   t0 = 0;
   int   mk;
   logic quick = 1'b0;
   logic stuck = 1'b0;

   function automatic real f2r(input word_t w);
      real m;
      int  e;
      if (w[30:23] == 8'd0) return 0.0;
      m = 1.0 + real'(w[22:0]) / 8388608.0;
      e = int'(w[30:23]) - 127;
      m = m * (2.0 ** e);
      return w[31] ? -m : m;
   endfunction

   function automatic word_t r2f(input real r);
      logic [63:0] b;
      int          ex;
      if (r == 0.0) return 32'h0;
      b  = $realtobits(r);
      ex = int'(b[62:52]) - 896;
      return {b[63], ex[7:0], b[51:29]};
   endfunction

   // Adder bank model: ready stays stale for two cycles after load, results follow later.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         add_ready <= 1'b0;
         mk        <= 0;
         for (int i = 0; i < N; i++) add_result[i] <= 32'h0;
      end else if (add_load) begin
         if (quick) begin
            for (int i = 0; i < N; i++) add_result[i] <= r2f(f2r(add_a[i]) + f2r(add_b[i]));
            add_ready <= 1'b1;
            mk        <= 0;
         end else begin
            mk <= 1;
         end
      end else if (mk != 0) begin
         mk <= mk + 1;
         if (mk == 2) add_ready <= 1'b0;
         if (mk == 4) begin
            mk <= 0;
            if (!stuck) begin
               for (int i = 0; i < N; i++) add_result[i] <= r2f(f2r(add_a[i]) + f2r(add_b[i]));
               add_ready <= 1'b1;
            end
         end
      end
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (add_load) load_cnt <= load_cnt + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input word_t w);
      int t;
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      t = 0;
      while (!bus.in_ready && t < 50) begin
         tick();
         t++;
      end
      if (t >= 50) chk("send_timeout", 32'(t), 32'd0);
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic fill(input int v, input int gap, input int start);
      lc_start = load_cnt;
      for (int i = start; i < 4; i++) begin
         send(vecs[v].a[i]);
         if (gap != 0 && i == 1) repeat (3) tick();
      end
      for (int i = 0; i < 4; i++) send(vecs[v].b[i]);
      t0 = cyc;
      chk("no_early_load", 32'(load_cnt - lc_start), 32'd0);
      chk("load_after_b3", add_load, 1'b1);
      chk("in_ready_in_load", bus.in_ready, 1'b0);
      chk("busy_in_load", busy, 1'b1);
   endtask

   task automatic drain(input int v, input int pat, input int exp_lat, input int ov);
      int    k = 0;
      int    g = 0;
      logic  held_v = 1'b0;
      word_t held_d = 32'h0;
      bit    first = 1'b1;
      while (k < 4 && g < 200) begin
         bus.out_ready = (pat == 0) ? 1'b1 : ((g % 3) == 0);
         if (held_v) begin
            chk("hold_valid", bus.out_valid, 1'b1);
            chk("hold_data", bus.out_data, held_d);
         end
         held_v = 1'b0;
         if (bus.out_valid) begin
            if (first) begin
               chk("first_valid_latency", 32'(cyc - t0), 32'(exp_lat));
               first = 1'b0;
            end
            if (bus.out_ready) begin
               chk("out_data", bus.out_data, vecs[v].sum[k]);
               chk("out_last", bus.out_last, (k == 3));
               if (ov != 0 && k == 3) begin
                  bus.in_valid = 1'b1;
                  bus.in_data  = vecs[2].a[0];
                  chk("ovl_in_ready_drain", bus.in_ready, 1'b0);
               end
               k++;
            end else begin
               held_v = 1'b1;
               held_d = bus.out_data;
            end
         end
         tick();
         g++;
      end
      if (k < 4) chk("drain_timeout", 32'(k), 32'd4);
      bus.out_ready = 1'b0;
      chk("busy_after", busy, 1'b0);
      chk("valid_after", bus.out_valid, 1'b0);
      chk("in_ready_after", bus.in_ready, 1'b1);
      chk("one_load", 32'(load_cnt - lc_start), 32'd1);
      if (ov != 0) begin
         tick();
         bus.in_valid = 1'b0;
         chk("ovl_busy", busy, 1'b1);
         chk("ovl_a0", add_a[0], vecs[2].a[0]);
      end
   endtask

   initial begin
      int g;
      bus.in_valid  = 1'b0;
      bus.in_data   = 32'h0;
      bus.out_ready = 1'b0;

      vecs[0].a   = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F800000};
      vecs[0].b   = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40000000};
      vecs[0].sum = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40400000};
      vecs[1].a   = '{32'h3F000000, 32'h3FC00000, 32'hBF800000, 32'h40800000};
      vecs[1].b   = '{32'h3F000000, 32'h3F000000, 32'h40400000, 32'h40800000};
      vecs[1].sum = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h41000000};
      vecs[2].a   = '{32'h41200000, 32'h42C80000, 32'h3E800000, 32'h40E00000};
      vecs[2].b   = '{32'hC0000000, 32'h41E00000, 32'h3F400000, 32'h41100000};
      vecs[2].sum = '{32'h41000000, 32'h43000000, 32'h3F800000, 32'h41800000};

      tick();
      tick();
      chk("rst_in_ready", bus.in_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_load", add_load, 1'b0);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_out_last", bus.out_last, 1'b0);
      chk("rst_out_data", bus.out_data, 32'h0);
      for (int i = 0; i < N; i++) chk("rst_add_a", add_a[i], 32'h0);
      reset = 1'b1;
      tick();

      for (int v = 0; v < 3; v++) begin
         fill(v, 0, 0);
         drain(v, 0, 6, 0);
      end

      fill(0, 0, 0);
      drain(0, 1, 6, 0);

      fill(1, 1, 0);
      drain(1, 0, 6, 0);

      quick = 1'b1;
      fill(2, 0, 0);
      drain(2, 0, 4, 0);
      quick = 1'b0;

      fill(1, 0, 0);
      drain(1, 0, 6, 1);
      fill(2, 0, 1);
      drain(2, 0, 6, 0);

      for (int i = 0; i < 4; i++) send(vecs[0].a[i]);
      send(vecs[0].b[0]);
      send(vecs[0].b[1]);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_in_ready", bus.in_ready, 1'b1);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_a1", add_a[1], 32'h0);
      chk("mid_rst_b0", add_b[0], 32'h0);
      chk("mid_rst_load", add_load, 1'b0);
      #2 reset = 1'b1;
      tick();
      fill(0, 0, 0);
      drain(0, 0, 6, 0);

      fill(2, 0, 0);
      g = 0;
      while (!bus.out_valid && g < 100) begin
         tick();
         g++;
      end
      chk("pre_rst_valid", bus.out_valid, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk("async_valid_drop", bus.out_valid, 1'b0);
      chk("async_data_clr", bus.out_data, 32'h0);
      chk("async_busy_clr", busy, 1'b0);
      #2 reset = 1'b1;
      tick();

`ifdef TF_SEQ_TIMEOUT_EN
      stuck = 1'b1;
      fill(0, 0, 0);
      repeat (16) tick();
      chk("to_err_early", err, 1'b0);
      chk("to_busy_early", busy, 1'b1);
      tick();
      chk("to_err_set", err, 1'b1);
      chk("to_busy_clr", busy, 1'b0);
      chk("to_no_valid", bus.out_valid, 1'b0);
      stuck = 1'b0;
      send(vecs[0].a[0]);
      chk("to_err_clr", err, 1'b0);
      fill(0, 0, 1);
      drain(0, 0, 6, 0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/tf_operand_sequencer.md
Name: tf_operand_sequencer

Overview:
- Upstream/downstream controller for the element-wise matrix adder bank (WIDTH x WIDTH IEEE-754 single adders sharing one `load`, one AND-reduced `ready`).
- Accepts a serial 32-bit word stream: all A elements, then all B elements, row-major (index i*WIDTH+j). Holds them in operand banks.
- Issues the adder load, waits for completion, captures the result array, and streams results out serially with a valid/ready handshake and a last flag.

Parameters:
- WIDTH, 2, matrix dimension; element count N = WIDTH*WIDTH.
- SETTLE, 2, cycles after the load pulse during which add_ready is ignored, so stale ready from the previous operation is masked; must be >= 1.
- TIMEOUT, 1024, WAIT-state cycle limit; used only with the optional feature.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (all state cleared on negedge reset)
- in_valid  in  1  input word valid
- in_ready  out  1  sequencer can accept a word this cycle
- in_data  in  32  operand word
- add_load  out  1  load strobe to the adder bank
- add_ready  in  1  AND of all adder result_ready flags
- add_a  out  32 x N (unpacked array [N-1:0])  operand A bank
- add_b  out  32 x N (unpacked array [N-1:0])  operand B bank
- add_result  in  32 x N (unpacked array [N-1:0])  adder results
- out_valid  out  1  result word valid
- out_ready  in  1  consumer accepts the result word
- out_data  out  32  result word
- out_last  out  1  high with the final element (index N-1)
- busy  out  1  high in every state except IDLE

Behaviour:
- States:
  - IDLE: in_ready=1.
  - FILL_A
  - FILL_B
  - LOAD: exactly one cycle.
  - WAIT
  - DRAIN
- Reset values: state=IDLE; element counter=0; add_a/add_b all 0; captured results all 0; add_load=0; out_valid=0; out_last=0; out_data=0; busy=0; in_ready=1 (in_ready is combinational from state).
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready on a rising edge.
  - IDLE: the first transfer writes add_a[0] and moves to FILL_A with counter=1.
  - FILL_A: each transfer writes add_a[cnt]. When the transfer writes index N-1, move to FILL_B with counter=0.
  - FILL_B: each transfer writes add_b[cnt]. When the transfer writes index N-1, move to LOAD.
  - in_ready=1 only in IDLE, FILL_A and FILL_B.
- LOAD: add_load=1 for this single cycle, then move to WAIT. add_a/add_b stay stable from LOAD until the next IDLE->FILL_A transfer.
- WAIT:
  - A settle counter masks add_ready for SETTLE cycles.
  - After that, the first sampled add_ready=1 captures all N add_result words into the result bank, and the state moves to DRAIN with counter=0.
- DRAIN:
  - out_valid=1; out_data=result[cnt]; out_last = (cnt==N-1). These outputs are registered.
  - On out_valid && out_ready, cnt increments.
  - On the handshake with out_last, move to IDLE and drop out_valid.
  - out_data must not change while out_valid && !out_ready.
- Latency: the load pulse is asserted 1 cycle after the last B word is accepted. The first out_valid comes 1 cycle after the add_ready capture.
- Throughput: one input word per cycle; one output word per cycle under a continuous out_ready.
- Boundaries:
  - in_valid is ignored outside the fill states; no words are dropped or buffered.
  - WIDTH=1: N=1, and each of FILL_A and FILL_B completes on a single transfer.
  - add_ready held high permanently: the capture still waits SETTLE cycles.
  - Reset asserted mid-operation (any state): immediate return to reset values; a partial fill is discarded; out_valid drops asynchronously.
  - Simultaneous last-word handshake in DRAIN and a new in_valid: the word is not accepted that cycle (in_ready is still 0); it is accepted in IDLE on the next cycle.

Optional Feature:
- Macro: TF_SEQ_TIMEOUT_EN.
- When defined:
  - Adds output `err` (1 bit, reset 0) and a WAIT-cycle counter.
  - If WAIT lasts TIMEOUT cycles without a capture, err is set and the state moves to IDLE; no results are driven.
  - err is sticky until reset or the next accepted input word.
- When undefined: no err port, no counter, and WAIT may last indefinitely.

Decomposition:
- Shared package tf_pkg holds:
  - the typedef for a 32-bit float word;
  - the state enum (IDLE, FILL_A, FILL_B, LOAD, WAIT, DRAIN);
  - the constant for an element count function of WIDTH.
- One natural sub-module: tf_result_drain, covering result-bank capture plus the serial valid/ready/last output and its counter. The parent keeps the fill/load/wait FSM.

Test Plan:
- WIDTH=2, stream A={1.0,2.0,3.0,1.0}, B={1.0,1.0,1.0,2.0} (3F800000/40000000/40400000/…), real adder bank, out_ready=1 -> add_load pulses one cycle after the 8th word. Outputs are 40000000, 40400000, 40800000, 40400000 with out_last only on the 4th; busy falls after it.
- Backpressure: same data, out_ready toggles 1,0,0,1,… -> each word is held stable while stalled, no duplicates or skips, 4 handshakes total.
- Input gaps: in_valid low for 3 cycles between A[1] and A[2] -> correct fill; add_load occurs only after B[3].
- Stale ready: behavioural adder model holding add_ready=1 from the previous op, SETTLE=2 -> capture is no earlier than 3 cycles after add_load; the new results are returned.
- Reset mid-FILL_B (after 2 B words) -> all outputs at reset values at once, in_ready=1. The next full 8-word stream produces correct results.
- With TF_SEQ_TIMEOUT_EN and TIMEOUT=16, add_ready stuck 0 -> err=1 after 16 WAIT cycles, state IDLE, out_valid stays 0; err clears on the next accepted word.
